// File: rtl/gift_perm_ise.sv
// GIFT bit-permutation / S-box round helper: loads a 128- or 64-bit state in
// 2*DW chunks, applies one S-box + permutation (or its inverse), unloads DW bits at a time.
module gift_perm_ise #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [7:0]    sr,
    output logic [7:0]    sr_out,
    output logic [DW-1:0] result,
    output logic          wait_req
);

    generate
        if (!(DW == 8 || DW == 16 || DW == 32)) begin : g_bad_dw
            $error("gift_perm_ise: DW must be 8, 16 or 32");
        end
    endgenerate

    typedef enum logic [1:0] {LOAD, SBOX, PERM, OUT} state_t;

    localparam logic [4:0] W128 = 5'(64 / DW);
    localparam logic [4:0] W64  = 5'(32 / DW);
    localparam logic [4:0] U128 = 5'(128 / DW);
    localparam logic [4:0] U64  = 5'(64 / DW);

    state_t        r_fsm, w_fsm_nxt;
    logic [127:0]  r_state;
    logic [4:0]    r_cnt;
    logic [2:0]    r_mode;
    logic          r_rdy, r_ovf;
    logic [DW-1:0] r_result;

    logic          w_busy, w_go, w_abort, w_m64, w_load_last, w_out_last;
    logic [4:0]    w_wlen, w_ulen;
    logic [127:0]  w_load128, w_step;
    logic [63:0]   w_load64;
    logic [DW-1:0] w_first_word, w_next_word;
    logic          w_unused_sr;

    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        case (x)
            4'h0: sbox_fwd = 4'h1;  4'h1: sbox_fwd = 4'hA;  4'h2: sbox_fwd = 4'h4;  4'h3: sbox_fwd = 4'hC;
            4'h4: sbox_fwd = 4'h6;  4'h5: sbox_fwd = 4'hF;  4'h6: sbox_fwd = 4'h3;  4'h7: sbox_fwd = 4'h9;
            4'h8: sbox_fwd = 4'h2;  4'h9: sbox_fwd = 4'hD;  4'hA: sbox_fwd = 4'hB;  4'hB: sbox_fwd = 4'h7;
            4'hC: sbox_fwd = 4'h5;  4'hD: sbox_fwd = 4'h0;  4'hE: sbox_fwd = 4'h8;  default: sbox_fwd = 4'hE;
        endcase
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        case (x)
            4'h0: sbox_inv = 4'hD;  4'h1: sbox_inv = 4'h0;  4'h2: sbox_inv = 4'h8;  4'h3: sbox_inv = 4'h6;
            4'h4: sbox_inv = 4'h2;  4'h5: sbox_inv = 4'hC;  4'h6: sbox_inv = 4'h4;  4'h7: sbox_inv = 4'hB;
            4'h8: sbox_inv = 4'hE;  4'h9: sbox_inv = 4'h7;  4'hA: sbox_inv = 4'h1;  4'hB: sbox_inv = 4'hA;
            4'hC: sbox_inv = 4'h3;  4'hD: sbox_inv = 4'h9;  4'hE: sbox_inv = 4'hF;  default: sbox_inv = 4'h5;
        endcase
    endfunction

    function automatic logic [127:0] sbox_layer(input logic [127:0] x, input logic inv);
        logic [127:0] y;
        for (int n = 0; n < 32; n++)
            y[4*n +: 4] = inv ? sbox_inv(x[4*n +: 4]) : sbox_fwd(x[4*n +: 4]);
        return y;
    endfunction

    // Bits outside the active state width are left zero by construction.
    function automatic logic [127:0] perm_layer(input logic [127:0] x, input logic inv, input logic m64);
        logic [127:0] y;
        int k, p;
        y = '0;
        k = m64 ? 16 : 32;
        for (int i = 0; i < 128; i++) begin
            if (!m64 || i < 64) begin
                p = 4*(i/16) + k*((3*((i%16)/4) + (i%4)) % 4) + (i%4);
                if (inv) y[i[6:0]] = x[p[6:0]];
                else     y[p[6:0]] = x[i[6:0]];
            end
        end
        return y;
    endfunction

    assign w_busy      = (r_fsm == SBOX) || (r_fsm == PERM);
    assign w_go        = start && !sr[3] && !w_busy;
    assign w_abort     = start &&  sr[3] && !w_busy;
    assign w_m64       = (r_fsm == LOAD && r_cnt == 5'd0) ? sr[0] : r_mode[0];
    assign w_wlen      = w_m64 ? W64 : W128;
    assign w_ulen      = r_mode[0] ? U64 : U128;
    assign w_load_last = (r_cnt == w_wlen - 5'd1);
    assign w_out_last  = (r_cnt == w_ulen - 5'd2);
    assign w_load128   = {b, a, r_state[127:2*DW]};
    assign w_unused_sr = ^sr[7:4];

    generate
        if (DW == 32) begin : g_load64_full
            assign w_load64 = {b, a};
        end else begin : g_load64_shift
            assign w_load64 = {b, a, r_state[63:2*DW]};
        end
    endgenerate

    // Inverse order swaps the two compute cycles: permutation first, then S-box.
    always_comb begin
        w_step = r_state;
        case (r_fsm)
            SBOX: w_step = r_mode[1] ? perm_layer(r_state, 1'b1, r_mode[0])
                         : (r_mode[2] ? sbox_layer(r_state, 1'b0) : r_state);
            PERM: w_step = r_mode[1] ? (r_mode[2] ? sbox_layer(r_state, 1'b1) : r_state)
                         : perm_layer(r_state, 1'b0, r_mode[0]);
            default: w_step = r_state;
        endcase
        if (w_busy && r_mode[0])
            w_step[127:64] = '0;
    end

    assign w_first_word = r_mode[0] ? w_step[63 -: DW]       : w_step[127 -: DW];
    assign w_next_word  = r_mode[0] ? r_state[63-DW -: DW]   : r_state[127-DW -: DW];

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            LOAD: if (w_go && w_load_last) w_fsm_nxt = SBOX;
            SBOX: w_fsm_nxt = PERM;
            PERM: w_fsm_nxt = OUT;
            OUT:  if (w_abort || (w_go && w_out_last)) w_fsm_nxt = LOAD;
            default: w_fsm_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_fsm <= LOAD;
        else     r_fsm <= w_fsm_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= '0;
            r_cnt    <= '0;
            r_mode   <= '0;
            r_rdy    <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_fsm)
                LOAD: begin
                    if (w_abort) begin
                        r_cnt <= '0;
                        r_rdy <= 1'b0;
                        r_ovf <= 1'b0;
                    end else if (w_go) begin
                        r_state <= w_m64 ? {r_state[127:64], w_load64} : w_load128;
                        if (r_cnt == 5'd0) r_mode <= sr[2:0];
                        r_cnt <= w_load_last ? 5'd0 : r_cnt + 5'd1;
                    end
                end
                SBOX: begin
                    r_state <= w_step;
                    if (start) r_ovf <= 1'b1;
                end
                PERM: begin
                    r_state  <= w_step;
                    r_result <= w_first_word;
                    r_rdy    <= 1'b1;
                    r_cnt    <= '0;
                    if (start) r_ovf <= 1'b1;
                end
                OUT: begin
                    if (w_abort) begin
                        r_cnt <= '0;
                        r_rdy <= 1'b0;
                        r_ovf <= 1'b0;
                    end else if (w_go) begin
                        r_state  <= r_state << DW;
                        r_result <= w_next_word;
                        if (w_out_last) begin
                            r_cnt <= '0;
                            r_rdy <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign sr_out   = {3'b000, r_ovf, r_rdy, r_mode};
    assign result   = r_result;
    assign wait_req = w_busy;

endmodule

// File: tb/tb_gift_perm_ise.sv
// Directed bench for gift_perm_ise: DW=8 instance for all scenarios, DW=32 instance for the inverse round trip.
module tb_gift_perm_ise;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = '0, b = '0, sr = '0;
    logic [7:0]  sr_out, result;
    logic        wait_req;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0]  sr32 = '0;
    logic [7:0]  sr_out32;
    logic [31:0] result32;
    logic        wait32;

    int checks = 0;
    int failures = 0;

    gift_perm_ise #(.DW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sr(sr),
        .sr_out(sr_out), .result(result), .wait_req(wait_req)
    );

    gift_perm_ise #(.DW(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .sr(sr32),
        .sr_out(sr_out32), .result(result32), .wait_req(wait32)
    );

    localparam logic [127:0] X_RT   = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [127:0] E_BIT4 = 128'h0000_0000_0000_0000_0000_0002_0000_0000;
    localparam logic [127:0] E_SBIT = 128'h1111_1111_1111_1115_1111_1111_1111_1110;

    // Called at a falling edge; the start pulse is seen by exactly one rising edge.
    task automatic pulse(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] srv);
        a = av; b = bv; sr = srv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0; sr = '0;
    endtask

    task automatic pulse32(input logic [31:0] av, input logic [31:0] bv, input logic [7:0] srv);
        a32 = av; b32 = bv; sr32 = srv; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0; a32 = '0; b32 = '0; sr32 = '0;
    endtask

    task automatic load_block(input logic [127:0] x, input logic [7:0] srv);
        int n;
        n = srv[0] ? 4 : 8;
        for (int k = 0; k < n; k++) begin
            pulse(x[16*k +: 8], x[16*k+8 +: 8], srv);
            if (k < n-1) begin
                checks++;
                if (wait_req !== 1'b0) begin
                    failures++;
                    $display("FAIL load_wait_low: wait_req=%b expected 0 after load %0d", wait_req, k);
                end
            end
        end
    endtask

    task automatic wait_compute();
        int cnt;
        cnt = 0;
        for (int c = 0; c < 10 && wait_req === 1'b1; c++) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 2) begin
            failures++;
            $display("FAIL wait_cycles: got %0d cycles expected 2", cnt);
        end
    endtask

    task automatic unload(input bit m64, output logic [127:0] y);
        int n;
        n = m64 ? 8 : 16;
        y = '0;
        for (int k = 0; k < n; k++) begin
            y[8*(n-1-k) +: 8] = result;
            if (k < n-1) pulse(8'h00, 8'h00, 8'h00);
        end
    endtask

    task automatic run32(input logic [127:0] x, input logic [7:0] srv, output logic [127:0] y);
        for (int k = 0; k < 2; k++) pulse32(x[64*k +: 32], x[64*k+32 +: 32], srv);
        for (int c = 0; c < 10 && wait32 === 1'b1; c++) @(negedge clk);
        y = '0;
        for (int k = 0; k < 4; k++) begin
            y[32*(3-k) +: 32] = result32;
            if (k < 3) pulse32(32'h0, 32'h0, 8'h00);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (result !== 8'h00 || sr_out !== 8'h00 || wait_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_dw8: result=%h sr_out=%h wait=%b expected 00 00 0", result, sr_out, wait_req);
        end
        checks++;
        if (result32 !== 32'h0 || sr_out32 !== 8'h00 || wait32 !== 1'b0) begin
            failures++;
            $display("FAIL reset_dw32: result=%h sr_out=%h wait=%b expected 0 00 0", result32, sr_out32, wait32);
        end
    endtask

    task automatic test_perm_single();
        logic [127:0] y;
        load_block(128'h2, 8'h00);
        wait_compute();
        checks++;
        if (sr_out !== 8'h08 || result !== 8'h00) begin
            failures++;
            $display("FAIL perm_single_enter: sr_out=%h result=%h expected 08 00", sr_out, result);
        end
        unload(1'b0, y);
        checks++;
        if (y !== E_BIT4) begin
            failures++;
            $display("FAIL perm_single_data: got %h expected %h", y, E_BIT4);
        end
        checks++;
        if (sr_out !== 8'h00 || wait_req !== 1'b0) begin
            failures++;
            $display("FAIL perm_single_done: sr_out=%h wait=%b expected 00 0", sr_out, wait_req);
        end
    endtask

    task automatic test_sbox();
        logic [127:0] y;
        load_block(128'h0, 8'h04);
        wait_compute();
        checks++;
        if (sr_out !== 8'h0C) begin
            failures++;
            $display("FAIL sbox_zero_srout: got %h expected 0c", sr_out);
        end
        unload(1'b0, y);
        checks++;
        if (y !== {16{8'h11}}) begin
            failures++;
            $display("FAIL sbox_zero_data: got %h expected %h", y, {16{8'h11}});
        end
        checks++;
        if (sr_out !== 8'h04) begin
            failures++;
            $display("FAIL sbox_zero_done: sr_out=%h expected 04", sr_out);
        end
        load_block(128'h2, 8'h04);
        wait_compute();
        unload(1'b0, y);
        checks++;
        if (y !== E_SBIT) begin
            failures++;
            $display("FAIL sbox_bit_data: got %h expected %h", y, E_SBIT);
        end
    endtask

    task automatic test_gift64();
        logic [127:0] y;
        load_block(128'h2, 8'h01);
        wait_compute();
        checks++;
        if (sr_out !== 8'h09) begin
            failures++;
            $display("FAIL g64_srout: got %h expected 09", sr_out);
        end
        unload(1'b1, y);
        checks++;
        if (y[63:0] !== 64'h0000_0000_0002_0000) begin
            failures++;
            $display("FAIL g64_data: got %h expected 0000000000020000", y[63:0]);
        end
        checks++;
        if (sr_out !== 8'h01 || wait_req !== 1'b0) begin
            failures++;
            $display("FAIL g64_done: sr_out=%h wait=%b expected 01 0", sr_out, wait_req);
        end
    endtask

    task automatic test_inverse();
        logic [127:0] y;
        load_block(128'h2, 8'h02);
        wait_compute();
        unload(1'b0, y);
        checks++;
        if (y !== 128'h20) begin
            failures++;
            $display("FAIL inv_perm_data: got %h expected %h", y, 128'h20);
        end
        load_block(128'h0, 8'h06);
        wait_compute();
        unload(1'b0, y);
        checks++;
        if (y !== {16{8'hDD}}) begin
            failures++;
            $display("FAIL inv_sbox_data: got %h expected %h", y, {16{8'hDD}});
        end
        load_block(128'h0, 8'h07);
        wait_compute();
        unload(1'b1, y);
        checks++;
        if (y[63:0] !== {8{8'hDD}}) begin
            failures++;
            $display("FAIL inv_g64_data: got %h expected %h", y[63:0], {8{8'hDD}});
        end
    endtask

    task automatic test_roundtrip();
        logic [127:0] y, z;
        load_block(X_RT, 8'h04);
        wait_compute();
        unload(1'b0, y);
        load_block(y, 8'h06);
        wait_compute();
        unload(1'b0, z);
        checks++;
        if (z !== X_RT) begin
            failures++;
            $display("FAIL roundtrip_dw8: got %h expected %h", z, X_RT);
        end
        run32(X_RT, 8'h04, y);
        run32(y, 8'h06, z);
        checks++;
        if (z !== X_RT) begin
            failures++;
            $display("FAIL roundtrip_dw32: got %h expected %h", z, X_RT);
        end
    endtask

    task automatic test_overrun();
        logic [127:0] y;
        load_block(128'h2, 8'h00);
        @(negedge clk);
        pulse(8'hFF, 8'hFF, 8'h00);
        checks++;
        if (sr_out !== 8'h18) begin
            failures++;
            $display("FAIL overrun_srout: got %h expected 18", sr_out);
        end
        unload(1'b0, y);
        checks++;
        if (y !== E_BIT4) begin
            failures++;
            $display("FAIL overrun_data: got %h expected %h", y, E_BIT4);
        end
        pulse(8'h00, 8'h00, 8'h08);
        checks++;
        if (sr_out !== 8'h00 || wait_req !== 1'b0) begin
            failures++;
            $display("FAIL overrun_abort: sr_out=%h wait=%b expected 00 0", sr_out, wait_req);
        end
    endtask

    task automatic test_abort();
        logic [127:0] y;
        for (int k = 0; k < 3; k++) pulse(8'hAA, 8'h55, 8'h01);
        pulse(8'h00, 8'h00, 8'h08);
        checks++;
        if (sr_out !== 8'h01) begin
            failures++;
            $display("FAIL abort_load_srout: got %h expected 01", sr_out);
        end
        load_block(128'h2, 8'h00);
        wait_compute();
        unload(1'b0, y);
        checks++;
        if (y !== E_BIT4) begin
            failures++;
            $display("FAIL abort_load_next: got %h expected %h", y, E_BIT4);
        end
        load_block(128'h0, 8'h04);
        wait_compute();
        pulse(8'h00, 8'h00, 8'h00);
        pulse(8'h00, 8'h00, 8'h00);
        pulse(8'h00, 8'h00, 8'h08);
        checks++;
        if (sr_out !== 8'h04 || wait_req !== 1'b0) begin
            failures++;
            $display("FAIL abort_out_srout: sr_out=%h wait=%b expected 04 0", sr_out, wait_req);
        end
        load_block(128'h2, 8'h01);
        wait_compute();
        unload(1'b1, y);
        checks++;
        if (y[63:0] !== 64'h0000_0000_0002_0000) begin
            failures++;
            $display("FAIL abort_out_next: got %h expected 0000000000020000", y[63:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] y;
        load_block(128'h2, 8'h00);
        wait_compute();
        repeat (5) pulse(8'h00, 8'h00, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (result !== 8'h00 || sr_out !== 8'h00 || wait_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_unload: result=%h sr_out=%h wait=%b expected 00 00 0", result, sr_out, wait_req);
        end
        load_block(128'h2, 8'h04);
        wait_compute();
        unload(1'b0, y);
        checks++;
        if (y !== E_SBIT) begin
            failures++;
            $display("FAIL reset_mid_next: got %h expected %h", y, E_SBIT);
        end
        for (int k = 0; k < 3; k++) pulse(8'h5A, 8'hA5, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load_block(128'h2, 8'h00);
        wait_compute();
        unload(1'b0, y);
        checks++;
        if (y !== E_BIT4) begin
            failures++;
            $display("FAIL reset_mid_load: got %h expected %h", y, E_BIT4);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_perm_single();
        test_sbox();
        test_gift64();
        test_inverse();
        test_roundtrip();
        test_overrun();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
